flash_fetch_ctrl: RTL and testbench

FLASH_FETCH_CTRL -- requirements
Module: flash_fetch_ctrl

---
 rtl/flash_fetch_ctrl.sv | 159 +++++++++++++++
 tb/tb_flash_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_fetch_ctrl.sv
// Fetches one 16-bit instruction as two byte reads from parallel flash, low byte first.
// Optional one-entry word cache enabled by defining FLASH_FETCH_CACHE_EN.
module flash_fetch_ctrl #(
  parameter int unsigned WAIT_CYCLES = 4,
  parameter logic [21:0] FLASH_BASE  = 22'h000000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        req,
  input  logic [15:0] addr,
  output logic        rdy,
  output logic [15:0] insn,
  output logic        busy,
  output logic [21:0] FL_ADDR,
  input  logic [7:0]  FL_DQ,
  output logic        FL_CE_N,
  output logic        FL_OE_N
);

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_rdy, w_rdy_nxt;
  logic [15:0] r_insn, w_insn_nxt;
  logic [21:0] r_fl_addr, w_fl_addr_nxt;
  logic        r_fl_off, w_fl_off_nxt;

  logic [3:0]  w_cnt_dec;
  logic        w_last;
  logic        w_fetch_done;
  logic        w_hit;
  logic [15:0] w_cache_word;

  assign w_cnt_dec    = r_cnt - 4'd1;
  assign w_last       = (w_cnt_dec == 4'd0);
  assign w_fetch_done = (r_state == WAIT_HI) && req && w_last;

`ifdef FLASH_FETCH_CACHE_EN
  logic        r_cache_vld;
  logic [15:0] r_cache_addr;
  logic [15:0] r_cache_word;
  logic [15:0] r_req_addr;

  assign w_hit        = r_cache_vld && (addr == r_cache_addr);
  assign w_cache_word = r_cache_word;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_cache_vld <= 1'b0;
    end else if (w_fetch_done) begin
      r_cache_vld <= 1'b1;
    end
  end

  // NOTE: the cache payload needs no reset; it is never used while r_cache_vld is low.
  always_ff @(posedge CLOCK_50) begin
    if (r_state == IDLE && req) begin
      r_req_addr <= addr;
    end
    if (w_fetch_done) begin
      r_cache_addr <= r_req_addr;
      r_cache_word <= {FL_DQ, r_insn[7:0]};
    end
  end
`else
  assign w_hit        = 1'b0;
  assign w_cache_word = 16'h0000;
`endif

  // NOTE: every next-state value gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rdy_nxt     = r_rdy;
    w_insn_nxt    = r_insn;
    w_fl_addr_nxt = r_fl_addr;
    w_fl_off_nxt  = r_fl_off;

    unique case (r_state)
      IDLE: begin
        if (req) begin
          if (w_hit) begin
            w_state_nxt = DONE;
            w_rdy_nxt   = 1'b1;
            w_insn_nxt  = w_cache_word;
          end else begin
            w_state_nxt   = WAIT_LO;
            w_cnt_nxt     = CNT_LOAD;
            w_fl_addr_nxt = FLASH_BASE + {6'b0, addr, 1'b0};
            w_fl_off_nxt  = 1'b0;
          end
        end
      end

      WAIT_LO, WAIT_HI: begin
        if (!req) begin
          // Abort: drop the flash bus, keep whatever byte was already captured.
          w_state_nxt   = IDLE;
          w_cnt_nxt     = 4'd0;
          w_fl_addr_nxt = 22'h0;
          w_fl_off_nxt  = 1'b1;
        end else if (!w_last) begin
          w_cnt_nxt = w_cnt_dec;
        end else if (r_state == WAIT_LO) begin
          w_insn_nxt[7:0]  = FL_DQ;
          w_fl_addr_nxt[0] = 1'b1;
          w_cnt_nxt        = CNT_LOAD;
          w_state_nxt      = WAIT_HI;
        end else begin
          w_insn_nxt[15:8] = FL_DQ;
          w_rdy_nxt        = 1'b1;
          w_cnt_nxt        = 4'd0;
          w_state_nxt      = DONE;
        end
      end

      DONE: begin
        if (!req) begin
          w_state_nxt   = IDLE;
          w_rdy_nxt     = 1'b0;
          w_fl_addr_nxt = 22'h0;
          w_fl_off_nxt  = 1'b1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_rdy     <= 1'b0;
      r_insn    <= 16'h0000;
      r_fl_addr <= 22'h0;
      r_fl_off  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rdy     <= w_rdy_nxt;
      r_insn    <= w_insn_nxt;
      r_fl_addr <= w_fl_addr_nxt;
      r_fl_off  <= w_fl_off_nxt;
    end
  end

  assign rdy     = r_rdy;
  assign insn    = r_insn;
  assign busy    = (r_state != IDLE);
  assign FL_ADDR = r_fl_addr;
  assign FL_CE_N = r_fl_off;
  assign FL_OE_N = r_fl_off;

endmodule

// File: tb/tb_flash_fetch_ctrl.sv
// Scoreboard bench for flash_fetch_ctrl: a flash byte model, a word-level reference
// model feeding an expectation queue, and a monitor that checks every rdy rise.
module tb_flash_fetch_ctrl;

  localparam int          W     = 4;
  localparam logic [21:0] BASE  = 22'h000000;
  localparam logic [21:0] BASE2 = 22'h3FFFFE;

  typedef struct {
    logic [15:0] word;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, req, req2;
  logic [15:0] addr, addr2;
  logic        rdy, rdy2, busy, busy2;
  logic [15:0] insn, insn2;
  logic [21:0] fl_addr, fl_addr2;
  logic [7:0]  fl_dq, fl_dq2;
  logic        fl_ce_n, fl_oe_n, fl_ce_n2, fl_oe_n2;

  logic [7:0]  mem [256];
  exp_t        sb_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  logic        m_cache_vld = 1'b0;
  logic [15:0] m_cache_addr = 16'h0;
  logic [15:0] m_insn = 16'h0;
  logic        prev_rdy = 1'b0;
  logic [15:0] prev_insn = 16'h0;
  logic [21:0] prev_addr = 22'h0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] flash_byte(input logic [21:0] a);
    return mem[a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]}];
  endfunction

  function automatic logic [21:0] lo_addr(input logic [15:0] a, input logic [21:0] b);
    return 22'((int'(b) + 2 * int'(a)) % 4194304);
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a, input logic [21:0] b);
    logic [21:0] lo;
    lo = lo_addr(a, b);
    return {flash_byte(lo | 22'h1), flash_byte(lo)};
  endfunction

  assign fl_dq  = flash_byte(fl_addr);
  assign fl_dq2 = flash_byte(fl_addr2);

  flash_fetch_ctrl #(.WAIT_CYCLES(W), .FLASH_BASE(BASE)) u_dut (
    .CLOCK_50(clk), .reset(reset), .req(req), .addr(addr), .rdy(rdy), .insn(insn),
    .busy(busy), .FL_ADDR(fl_addr), .FL_DQ(fl_dq), .FL_CE_N(fl_ce_n), .FL_OE_N(fl_oe_n)
  );

  flash_fetch_ctrl #(.WAIT_CYCLES(W), .FLASH_BASE(BASE2)) u_dut_wrap (
    .CLOCK_50(clk), .reset(reset), .req(req2), .addr(addr2), .rdy(rdy2), .insn(insn2),
    .busy(busy2), .FL_ADDR(fl_addr2), .FL_DQ(fl_dq2), .FL_CE_N(fl_ce_n2), .FL_OE_N(fl_oe_n2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per rdy rise; also checks hold and idle invariants.
  always @(negedge clk) begin
    if (cyc > 2) begin
      if (rdy && !prev_rdy) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rdy: got rdy=1 with insn %h, expected no rdy (cycle %0d)", insn, cyc);
        end else begin
          mon_e = sb_q.pop_front();
          check("insn", 32'(insn), 32'(mon_e.word));
          check("latency_cycle", cyc, mon_e.cyc);
        end
      end
      if (rdy && prev_rdy) begin
        check("insn_hold", 32'(insn), 32'(prev_insn));
        check("addr_hold", 32'(fl_addr), 32'(prev_addr));
      end
      if (!busy) begin
        check("idle_rdy", 32'(rdy), 32'd0);
        check("idle_ce_oe", {30'd0, fl_ce_n, fl_oe_n}, 32'd3);
        check("idle_fl_addr", 32'(fl_addr), 32'd0);
      end
    end
    prev_rdy  <= rdy;
    prev_insn <= insn;
    prev_addr <= fl_addr;
  end

  // One CPU request; abort_at in 1..2W drops req that many cycles after acceptance.
  task automatic fetch(input logic [15:0] a, input int abort_at, input int hold);
    int          c;
    int          lat;
    int          n;
    int          ab;
    logic        hit;
    logic [15:0] w;
    ab  = abort_at;
    hit = 1'b0;
`ifdef FLASH_FETCH_CACHE_EN
    hit = m_cache_vld && (m_cache_addr == a);
`endif
    if (hit) ab = 0;
    w   = exp_word(a, BASE);
    lat = hit ? 2 : 2 * W + 2;
    @(negedge clk);
    req  = 1'b1;
    addr = a;
    c    = cyc;
    if (ab == 0) sb_q.push_back('{w, c + lat - 1});
    @(negedge clk);
    check("ce_n_after_accept", 32'(fl_ce_n), 32'(hit));
    check("fl_addr_lo", 32'(fl_addr), hit ? 32'd0 : 32'(lo_addr(a, BASE)));
    if (ab != 0) begin
      repeat (ab - 1) @(negedge clk);
      req = 1'b0;
      if (ab > W) m_insn[7:0] = w[7:0];
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_insn", 32'(insn), 32'(m_insn));
    end else begin
      if (!hit) begin
        repeat (W) @(negedge clk);
        check("fl_addr_hi", 32'(fl_addr), 32'(lo_addr(a, BASE) | 22'h1));
      end
      n = 0;
      while (!rdy && n < 2 * W + 8) begin
        @(negedge clk);
        n++;
      end
      if (!rdy) begin
        n_vec++;
        n_err++;
        $display("FAIL rdy_timeout: got no rdy for addr %h, expected rdy within %0d cycles", a, lat);
      end
      repeat (hold) @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      check("release_busy", 32'(busy), 32'd0);
      check("release_insn_kept", 32'(insn), 32'(w));
      m_insn       = w;
      m_cache_vld  = 1'b1;
      m_cache_addr = a;
    end
  endtask

  task automatic reset_mid_fetch(input logic [15:0] a);
    @(negedge clk);
    req  = 1'b1;
    addr = a;
    repeat (W + 2) @(negedge clk);
    check("busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    check("rst_rdy", 32'(rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_insn", 32'(insn), 32'd0);
    check("rst_fl_addr", 32'(fl_addr), 32'd0);
    check("rst_ce_oe", {30'd0, fl_ce_n, fl_oe_n}, 32'd3);
    reset        = 1'b0;
    m_insn       = 16'h0;
    m_cache_vld  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish before 200000 time units");
    $fatal(1);
  end

  initial begin
    logic [15:0] a;
    logic [15:0] last_a;
    int          n;
    reset = 1'b1;
    req   = 1'b0;
    req2  = 1'b0;
    addr  = 16'h0;
    addr2 = 16'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[2] = 8'h34;
    mem[3] = 8'h12;
    repeat (3) @(negedge clk);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_insn", 32'(insn), 32'd0);
    check("reset_fl_addr", 32'(fl_addr), 32'd0);
    check("reset_ce_oe", {30'd0, fl_ce_n, fl_oe_n}, 32'd3);
    check("reset_wrap_busy", 32'(busy2), 32'd0);
    reset = 1'b0;

    // Basic fetch, long hold in DONE, then abort and recovery.
    fetch(16'h0001, 0, 20);
    check("word_0001", 32'(insn), 32'h1234);
    fetch(16'h0010, 2, 0);
    fetch(16'h0020, 0, 0);
    fetch(16'h0030, 2 * W, 0);
    fetch(16'h0040, W, 1);
    reset_mid_fetch(16'h0050);

    // Repeat address (cache hit when enabled), then a new address.
    fetch(16'h0005, 0, 0);
    fetch(16'h0005, 0, 2);
    fetch(16'h0006, 0, 0);

    last_a = 16'h0006;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? last_a : 16'($urandom);
      fetch(a, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * W)) : 0,
            int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      last_a = a;
    end

    // 22-bit wrap-around of the flash address.
    @(negedge clk);
    req2  = 1'b1;
    addr2 = 16'hFFFF;
    @(negedge clk);
    check("wrap_fl_addr_lo", 32'(fl_addr2), 32'h01FFFC);
    repeat (W) @(negedge clk);
    check("wrap_fl_addr_hi", 32'(fl_addr2), 32'h01FFFD);
    n = 0;
    while (!rdy2 && n < 2 * W + 8) begin
      @(negedge clk);
      n++;
    end
    check("wrap_rdy", 32'(rdy2), 32'd1);
    check("wrap_insn", 32'(insn2), {16'd0, flash_byte(22'h01FFFD), flash_byte(22'h01FFFC)});
    req2 = 1'b0;

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pending_expectations: got %0d unmatched, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
